// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, default
// oversampling ratio and the legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchroniser plus 3-sample majority vote
// around the bit centre (counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rx,
  input  logic                          i_tick,
  input  logic [$clog2(OVERSAMPLE)-1:0] i_cnt,
  output logic                          o_rx_sync,
  output logic                          o_vote
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_A = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_B = CW'(OVERSAMPLE / 2);

  logic r_sync1;
  logic r_sync2;
  logic r_smp_a;
  logic r_smp_b;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // The first two samples are held; the third is the live value at the vote tick.
  always_ff @(posedge clk) begin
    if (i_tick && (i_cnt == CNT_A)) r_smp_a <= r_sync2;
    if (i_tick && (i_cnt == CNT_B)) r_smp_b <= r_sync2;
  end

  assign o_rx_sync = r_sync2;
  assign o_vote    = maj3(r_smp_a, r_smp_b, r_sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver (LSB first, 1-2 stop bits, break lockout).
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_baud_tick,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_frame: STOP_BITS out of range");
  end

  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic                 r_stopcnt;
  logic                 r_armed;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_done;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr;
  logic                 r_parity_err;
`endif

  logic          w_rx_sync;
  logic          w_vote;
  logic [CW-1:0] w_cnt_nxt;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .i_rx     (i_rx),
    .i_tick   (i_baud_tick),
    .i_cnt    (r_cnt),
    .o_rx_sync(w_rx_sync),
    .o_vote   (w_vote)
  );

  assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

  // Data-only shift register: every bit is overwritten before it is used.
  always_ff @(posedge clk) begin
    if (i_baud_tick && (r_state == ST_DATA) && (r_cnt == CNT_VOTE))
      r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_stopcnt   <= 1'b0;
      r_armed     <= 1'b1;
      r_ferr      <= 1'b0;
      r_rx_data   <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_baud_tick) begin
        if (w_rx_sync) r_armed <= 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (!w_rx_sync && r_armed) begin
              r_state <= ST_START;
              r_cnt   <= CW'(1);
              r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_perr  <= 1'b0;
`endif
            end
          end
          ST_START: begin
            if ((r_cnt == CNT_VOTE) && w_vote) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_nxt;
              if (r_cnt == CNT_LAST) begin
                r_state  <= ST_DATA;
                r_bitcnt <= '0;
              end
            end
          end
          ST_DATA: begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == CNT_VOTE) r_bitcnt <= r_bitcnt + 1'b1;
            if ((r_cnt == CNT_LAST) && (r_bitcnt == BITS_LAST)) begin
              r_stopcnt <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_state   <= ST_PARITY;
`else
              r_state   <= ST_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            r_cnt <= w_cnt_nxt;
            if ((r_cnt == CNT_VOTE) && (w_vote != ((^r_shreg) ^ i_parity_odd)))
              r_perr <= 1'b1;
            if (r_cnt == CNT_LAST) r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            if ((r_cnt == CNT_VOTE) && (r_stopcnt == STOP_LAST)) begin
              // Finish at mid stop bit so a back-to-back start edge is not missed.
              r_state     <= ST_IDLE;
              r_cnt       <= '0;
              r_rx_data   <= r_shreg;
              r_frame_err <= r_ferr | ~w_vote;
              r_done      <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_perr;
`endif
              if (r_ferr || !w_vote) r_armed <= 1'b0;
            end else begin
              r_cnt <= w_cnt_nxt;
              if ((r_cnt == CNT_VOTE) && !w_vote) r_ferr <= 1'b1;
              if (r_cnt == CNT_LAST) r_stopcnt <= r_stopcnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  // Parity select has no function without a parity bit in the frame.
  assign o_parity_err = i_parity_odd & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance and a 7-bit/2-stop
// instance, driven one baud tick per line value.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB8 = 1 + 8 + int'(PAR) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       par_odd = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       done8, ferr8, perr8, busy8;
  logic       done7, ferr7, perr7, busy7;

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) u_dut8 (
    .clk(clk), .reset(reset), .i_rx(rx8), .i_baud_tick(tick), .i_parity_odd(par_odd),
    .o_rx_data(data8), .o_rx_done(done8), .o_frame_err(ferr8), .o_parity_err(perr8),
    .o_busy(busy8)
  );

  uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2)) u_dut7 (
    .clk(clk), .reset(reset), .i_rx(rx7), .i_baud_tick(tick), .i_parity_odd(par_odd),
    .o_rx_data(data7), .o_rx_done(done7), .o_frame_err(ferr7), .o_parity_err(perr7),
    .o_busy(busy7)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut8_unexpected_done actual_data=%0h expected=no_done", data8);
      end else begin
        e8 = q8.pop_front();
        chk("dut8_frame", {21'b0, 1'b0, data8, ferr8, perr8}, {21'b0, e8});
      end
    end
    if (!reset && done7) begin
      if (q7.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut7_unexpected_done actual_data=%0h expected=no_done", data7);
      end else begin
        e7 = q7.pop_front();
        chk("dut7_frame", {21'b0, 2'b0, data7, ferr7, perr7}, {21'b0, e7});
      end
    end
  end

  // One line value per baud tick; rx settles two clocks before the tick.
  task automatic slot(input logic v8, input logic v7);
    rx8 = v8;
    rx7 = v7;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, 1'b1);
  endtask

  function automatic logic par_of(input logic [8:0] d, input int n, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < n; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic send(input bit to7, input logic [8:0] d, input int nbits, input int nstop,
                      input logic pbit, input logic [1:0] stop_v, input bit noise,
                      input int max_slots);
    logic bits[$];
    logic v;
    int   n;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (PAR) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stop_v[i]);
    n = 0;
    for (int k = 0; k < bits.size(); k++) begin
      for (int s = 0; s < OS; s++) begin
        v = bits[k];
        if (noise && (s == OS / 2 - 1 + (k % 3))) v = ~v;
        if (max_slots == 0 || n < max_slots) begin
          if (to7) slot(1'b1, v);
          else     slot(v, 1'b1);
        end
        n++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data8", {24'b0, data8}, 32'h0);
    chk("rst_done8", {31'b0, done8}, 32'h0);
    chk("rst_ferr8", {31'b0, ferr8}, 32'h0);
    chk("rst_perr8", {31'b0, perr8}, 32'h0);
    chk("rst_busy8", {31'b0, busy8}, 32'h0);
    chk("rst_data7", {25'b0, data7}, 32'h0);
    chk("rst_busy7", {31'b0, busy7}, 32'h0);
    reset = 1'b0;
    idle(4);

    q8.push_back('{9'h0A5, 1'b0, 1'b0});
    q8.push_back('{9'h03C, 1'b0, 1'b0});
    send(1'b0, 9'h0A5, 8, 1, par_of(9'h0A5, 8, 1'b0), 2'b11, 1'b0, 0);
    send(1'b0, 9'h03C, 8, 1, par_of(9'h03C, 8, 1'b0), 2'b11, 1'b0, 0);
    idle(8);

    for (int i = 0; i < 4; i++) slot(1'b0, 1'b1);
    chk("glitch_busy", {31'b0, busy8}, 32'h1);
    idle(12);
    chk("glitch_idle", {31'b0, busy8}, 32'h0);
    chk("glitch_data_held", {24'b0, data8}, 32'h3C);

    q8.push_back('{9'h05A, 1'b0, 1'b0});
    send(1'b0, 9'h05A, 8, 1, par_of(9'h05A, 8, 1'b0), 2'b11, 1'b1, 0);
    idle(8);

    q8.push_back('{9'h0FF, 1'b1, 1'b0});
    send(1'b0, 9'h0FF, 8, 1, par_of(9'h0FF, 8, 1'b0), 2'b00, 1'b0, 0);
    for (int i = 0; i < 2 * OS * NB8; i++) slot(1'b0, 1'b1);
    chk("break_ferr_held", {31'b0, ferr8}, 32'h1);
    idle(2 * OS);
    q8.push_back('{9'h012, 1'b0, 1'b0});
    send(1'b0, 9'h012, 8, 1, par_of(9'h012, 8, 1'b0), 2'b11, 1'b0, 0);
    idle(8);

`ifdef UART_RX_PARITY_EN
    par_odd = 1'b1;
    q8.push_back('{9'h007, 1'b0, 1'b0});
    send(1'b0, 9'h007, 8, 1, 1'b0, 2'b11, 1'b0, 0);
    q8.push_back('{9'h000, 1'b0, 1'b0});
    send(1'b0, 9'h000, 8, 1, 1'b1, 2'b11, 1'b0, 0);
    q8.push_back('{9'h007, 1'b0, 1'b1});
    send(1'b0, 9'h007, 8, 1, 1'b1, 2'b11, 1'b0, 0);
    idle(8);
    par_odd = 1'b0;
`endif

    q7.push_back('{9'h041, 1'b1, 1'b0});
    send(1'b1, 9'h041, 7, 2, par_of(9'h041, 7, 1'b0), 2'b01, 1'b0, 0);
    idle(2 * OS);
    chk("dut7_ferr_held", {31'b0, ferr7}, 32'h1);

    send(1'b1, 9'h055, 7, 2, par_of(9'h055, 7, 1'b0), 2'b11, 1'b0, 4 * OS);
    chk("mid_busy7", {31'b0, busy7}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_data7", {25'b0, data7}, 32'h0);
    chk("midrst_ferr7", {31'b0, ferr7}, 32'h0);
    chk("midrst_perr7", {31'b0, perr7}, 32'h0);
    chk("midrst_done7", {31'b0, done7}, 32'h0);
    chk("midrst_busy7", {31'b0, busy7}, 32'h0);
    chk("midrst_data8", {24'b0, data8}, 32'h0);
    reset = 1'b0;
    idle(8 * OS);

    q7.push_back('{9'h02A, 1'b0, 1'b0});
    send(1'b1, 9'h02A, 7, 2, par_of(9'h02A, 7, 1'b0), 2'b11, 1'b0, 0);
    idle(2 * OS);

    chk("dut8_pending", q8.size(), 32'h0);
    chk("dut7_pending", q7.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
